bp_request_sequencer: RTL and testbench
=======================================

// Module: bp_request_sequencer
// PURPOSE
//  Front end of the gshare predictor. Accepts branch-prediction requests from fetch and
//  resolve (update) requests from execute. Buffers them and issues one operation at a time
//  to the gshare control path over its start_pred/start_resolve/done handshake.
//  Holds the operands stable until the control path reports done.
// PARAMETERS
//  W          32  PC/target width
//  RQ_DEPTH    4  resolve-queue entries (power of 2, >=2)
//  TIMEOUT    15  max WAIT cycles before abort (4-bit counter)
// PORTS
//  clk          in   1         clock
//  rst          in   1         reset, asynchronous, active-low
//  pred_valid   in   1         fetch prediction request
//  pred_pc      in   W         PC to predict
//  pred_ready   out  1         prediction slot empty
//  res_valid    in   1         execute resolve request
//  res_pc       in   W         resolved branch PC
//  res_taken    in   1         actual outcome
//  res_target   in   W         actual target
//  res_ready    out  1         resolve queue not full
//  start_pred   out  1         to control path
//  start_resolve out 1         to control path
//  op_pc        out  W         operand PC to datapath
//  op_taken     out  1         operand outcome (pr_br_taken source)
//  op_target    out  W         operand target
//  done         in   1         from control path
//  pred_done    out  1         1-cycle pulse: prediction finished
//  res_done     out  1         1-cycle pulse: resolve finished
//  busy         out  1         state != IDLE
//  timeout_err  out  1         sticky; cleared only by reset
// BEHAVIOUR
//  - Reset: all outputs 0 except pred_ready=1, res_ready=1. Queue empty, state IDLE.
//  - Accept pred when pred_valid&pred_ready; slot frees on the cycle of its pred_done.
//  - Push resolve when res_valid&res_ready. Pop at ISSUE. Full: res_ready=0, nothing dropped.
//  - Same-cycle push to empty queue: entry is eligible the next cycle.
//  - Priority in IDLE: resolve queue non-empty wins over pending pred (history update first).
//  - FSM IDLE->ISSUE->HOLD->WAIT->IDLE:
//    IDLE : work pending -> ISSUE; load op_* from selected source.
//    ISSUE: start_pred or start_resolve =1 (one only) for exactly 1 cycle.
//    HOLD : start_resolve stays 1 for resolve ops; start_pred=0. Covers control-path CALC.
//    WAIT : both starts 0; done=1 -> IDLE and assert pred_done/res_done the next cycle.
//  - op_pc/op_taken/op_target are stable from ISSUE through the cycle done is seen.
//    op_taken=0 for predictions.
//  - done outside WAIT is ignored.
//  - Latency: pred accepted cycle N, idle, queue empty -> ISSUE N+1, done N+3, pred_done N+4.
//  - Back-to-back ops: the next ISSUE can occur the cycle after done (N+4).
//  - WAIT counter: reaching TIMEOUT without done -> timeout_err=1 and IDLE.
//    The aborted op is discarded with no *_done pulse; a pred slot is freed.
//  - Reset mid-operation: immediate return to IDLE, queue flushed, starts deasserted.
// CONFIGURATION
//  BP_SEQ_STATS_EN defined: adds outputs stat_pred[15:0], stat_res[15:0], stat_stall[15:0].
//    These count completed preds, completed resolves, and cycles with res_valid&!res_ready.
//    All counters saturate at 16'hFFFF and reset to 0.
//  BP_SEQ_STATS_EN undefined: these ports and counters do not exist; behaviour otherwise identical.
// TESTING
//  1 single pred pc=0x1000 at N, done at N+3 -> start_pred=1 only at N+1, op_pc=0x1000, pred_done at N+4
//  2 resolve pc=0x2000 taken target=0x2400 -> start_resolve=1 for 2 cycles, op_taken=1, res_done once
//  3 pred and resolve same cycle -> resolve issued first, pred issued cycle after its done
//  4 push 5 resolves back-to-back, RQ_DEPTH=4 -> res_ready=0 after 4th, 5th accepted after first pop, FIFO order kept
//  5 done never returned -> timeout_err=1 after 15 WAIT cycles, busy=0, no *_done pulse
//  6 rst low during HOLD -> starts 0 same cycle, queue empty, pred_ready=res_ready=1; stats=0 if BP_SEQ_STATS_EN

Source files
------------

// File: rtl/bp_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bp_request_sequencer
// Description : gshare front end. Buffers fetch predictions and execute
//               resolves and issues one at a time to the control path.
//               Optional statistics counters: define BP_SEQ_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_request_sequencer #(
    parameter int W        = 32,
    parameter int RQ_DEPTH = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pred_valid_i,
    input  logic [W-1:0] pred_pc_i,
    output logic         pred_ready_o,
    input  logic         res_valid_i,
    input  logic [W-1:0] res_pc_i,
    input  logic         res_taken_i,
    input  logic [W-1:0] res_target_i,
    output logic         res_ready_o,
    output logic         start_pred_o,
    output logic         start_resolve_o,
    output logic [W-1:0] op_pc_o,
    output logic         op_taken_o,
    output logic [W-1:0] op_target_o,
    input  logic         done_i,
    output logic         pred_done_o,
    output logic         res_done_o,
    output logic         busy_o,
`ifdef BP_SEQ_STATS_EN
    output logic [15:0]  stat_pred_o,
    output logic [15:0]  stat_res_o,
    output logic [15:0]  stat_stall_o,
`endif
    output logic         timeout_err_o
);

    localparam int         AW        = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
    localparam logic [AW:0] RQ_FULL  = (AW+1)'(RQ_DEPTH);
    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [1:0]   state_q, state_d;

    logic         op_is_res_q, op_is_res_d;
    logic [W-1:0] op_pc_q, op_pc_d;
    logic         op_taken_q, op_taken_d;
    logic [W-1:0] op_target_q, op_target_d;

    // Prediction slot; pred_iss_q marks that the held pred is the op in flight.
    logic         pred_vld_q, pred_vld_d;
    logic         pred_iss_q, pred_iss_d;
    logic [W-1:0] pred_pc_q, pred_pc_d;

    logic [W-1:0] rq_pc_q     [RQ_DEPTH];
    logic [W-1:0] rq_target_q [RQ_DEPTH];
    logic         rq_taken_q  [RQ_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic [3:0]   wcnt_q, wcnt_d;
    logic         pred_done_q, res_done_q;
    logic         timeout_err_q;

    logic         w_pred_push, w_res_push, w_pop;
    logic         w_q_nonempty, w_pred_pending;
    logic         w_sel_res, w_sel_pred, w_go, w_load;
    logic         w_finish, w_pred_fin, w_res_fin, w_abort;
    logic [W-1:0] w_pred_src_pc;

    assign pred_ready_o   = !pred_vld_q;
    assign res_ready_o    = (count_q != RQ_FULL);
    assign w_pred_push    = pred_valid_i && pred_ready_o;
    assign w_res_push     = res_valid_i && res_ready_o;
    assign w_q_nonempty   = (count_q != '0);
    assign w_pred_pending = pred_vld_q && !pred_iss_q;
    assign w_pred_src_pc  = pred_vld_q ? pred_pc_q : pred_pc_i;

    // Resolves win; a resolve arriving into an empty queue also holds off a
    // prediction so history updates stay ahead of lookups.
    assign w_sel_res  = w_q_nonempty;
    assign w_sel_pred = !w_q_nonempty && !w_res_push && (w_pred_pending || w_pred_push);
    assign w_go       = w_sel_res || w_sel_pred;

    assign w_finish   = (state_q == S_WAIT) && done_i;
    assign w_pred_fin = w_finish && !op_is_res_q;
    assign w_res_fin  = w_finish && op_is_res_q;
    assign w_abort    = (state_q == S_WAIT) && !done_i && (wcnt_q == WAIT_LAST);
    assign w_load     = w_go && ((state_q == S_IDLE) || w_finish);
    assign w_pop      = (state_q == S_ISSUE) && op_is_res_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_go) state_d = S_ISSUE;
            S_ISSUE: state_d = S_HOLD;
            S_HOLD:  state_d = S_WAIT;
            S_WAIT: begin
                if (done_i) begin
                    state_d = w_go ? S_ISSUE : S_IDLE;
                end else if (wcnt_q == WAIT_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        start_pred_o    = 1'b0;
        start_resolve_o = 1'b0;
        busy_o          = (state_q != S_IDLE);
        case (state_q)
            S_ISSUE: begin
                start_pred_o    = !op_is_res_q;
                start_resolve_o = op_is_res_q;
            end
            S_HOLD:  start_resolve_o = op_is_res_q;
            default: begin
                start_pred_o    = 1'b0;
                start_resolve_o = 1'b0;
            end
        endcase
    end

    // ---------------- Datapath next-state ----------------
    always_comb begin
        op_is_res_d = op_is_res_q;
        op_pc_d     = op_pc_q;
        op_taken_d  = op_taken_q;
        op_target_d = op_target_q;
        if (w_load) begin
            op_is_res_d = w_sel_res;
            op_pc_d     = w_sel_res ? rq_pc_q[rd_ptr_q]     : w_pred_src_pc;
            op_taken_d  = w_sel_res ? rq_taken_q[rd_ptr_q]  : 1'b0;
            op_target_d = w_sel_res ? rq_target_q[rd_ptr_q] : '0;
        end

        pred_vld_d = pred_vld_q;
        pred_iss_d = pred_iss_q;
        pred_pc_d  = pred_pc_q;
        if (w_pred_fin || (w_abort && !op_is_res_q)) begin
            pred_vld_d = 1'b0;
            pred_iss_d = 1'b0;
        end
        if (w_pred_push) begin
            pred_vld_d = 1'b1;
            pred_pc_d  = pred_pc_i;
        end
        if (w_load && w_sel_pred) begin
            pred_iss_d = 1'b1;
        end

        rd_ptr_d = w_pop      ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = w_res_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q;
        case ({w_res_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        wcnt_d = (state_q == S_WAIT) ? wcnt_q + 1'b1 : 4'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_is_res_q   <= 1'b0;
            op_pc_q       <= '0;
            op_taken_q    <= 1'b0;
            op_target_q   <= '0;
            pred_vld_q    <= 1'b0;
            pred_iss_q    <= 1'b0;
            pred_pc_q     <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            wcnt_q        <= 4'd0;
            pred_done_q   <= 1'b0;
            res_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            op_is_res_q   <= op_is_res_d;
            op_pc_q       <= op_pc_d;
            op_taken_q    <= op_taken_d;
            op_target_q   <= op_target_d;
            pred_vld_q    <= pred_vld_d;
            pred_iss_q    <= pred_iss_d;
            pred_pc_q     <= pred_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            wcnt_q        <= wcnt_d;
            pred_done_q   <= w_pred_fin;
            res_done_q    <= w_res_fin;
            timeout_err_q <= timeout_err_q || w_abort;
        end
    end

    // Queue payload needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (w_res_push) begin
            rq_pc_q[wr_ptr_q]     <= res_pc_i;
            rq_taken_q[wr_ptr_q]  <= res_taken_i;
            rq_target_q[wr_ptr_q] <= res_target_i;
        end
    end

    assign op_pc_o       = op_pc_q;
    assign op_taken_o    = op_taken_q;
    assign op_target_o   = op_target_q;
    assign pred_done_o   = pred_done_q;
    assign res_done_o    = res_done_q;
    assign timeout_err_o = timeout_err_q;

`ifdef BP_SEQ_STATS_EN
    logic [15:0] stat_pred_q, stat_res_q, stat_stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_pred_q  <= 16'd0;
            stat_res_q   <= 16'd0;
            stat_stall_q <= 16'd0;
        end else begin
            if (w_pred_fin && (stat_pred_q != 16'hFFFF)) begin
                stat_pred_q <= stat_pred_q + 16'd1;
            end
            if (w_res_fin && (stat_res_q != 16'hFFFF)) begin
                stat_res_q <= stat_res_q + 16'd1;
            end
            if (res_valid_i && !res_ready_o && (stat_stall_q != 16'hFFFF)) begin
                stat_stall_q <= stat_stall_q + 16'd1;
            end
        end
    end

    assign stat_pred_o  = stat_pred_q;
    assign stat_res_o   = stat_res_q;
    assign stat_stall_o = stat_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_request_sequencer
// Description : directed self-checking bench for bp_request_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_request_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pred_valid = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        res_valid = 1'b0;
    logic [31:0] res_pc = '0;
    logic        res_taken = 1'b0;
    logic [31:0] res_target = '0;
    logic        done = 1'b0;
    logic        pred_ready, res_ready, start_pred, start_resolve;
    logic [31:0] op_pc, op_target;
    logic        op_taken, pred_done, res_done, busy, timeout_err;
`ifdef BP_SEQ_STATS_EN
    logic [15:0] stat_pred, stat_res, stat_stall;
`endif

    int checks   = 0;
    int failures = 0;

    bp_request_sequencer #(.W(32), .RQ_DEPTH(4), .TIMEOUT(15)) dut (
        .clk             (clk),
        .rst             (rst),
        .pred_valid_i    (pred_valid),
        .pred_pc_i       (pred_pc),
        .pred_ready_o    (pred_ready),
        .res_valid_i     (res_valid),
        .res_pc_i        (res_pc),
        .res_taken_i     (res_taken),
        .res_target_i    (res_target),
        .res_ready_o     (res_ready),
        .start_pred_o    (start_pred),
        .start_resolve_o (start_resolve),
        .op_pc_o         (op_pc),
        .op_taken_o      (op_taken),
        .op_target_o     (op_target),
        .done_i          (done),
        .pred_done_o     (pred_done),
        .res_done_o      (res_done),
        .busy_o          (busy),
`ifdef BP_SEQ_STATS_EN
        .stat_pred_o     (stat_pred),
        .stat_res_o      (stat_res),
        .stat_stall_o    (stat_stall),
`endif
        .timeout_err_o   (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pred_ready !== 1'b1) begin failures++; $display("FAIL rst_pred_ready got %b want 1", pred_ready); end
        checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL rst_res_ready got %b want 1", res_ready); end
        checks++; if ({start_pred, start_resolve, busy, pred_done, res_done, timeout_err} !== 6'b0) begin failures++; $display("FAIL rst_ctrl got %b want 000000", {start_pred, start_resolve, busy, pred_done, res_done, timeout_err}); end
        checks++; if ({op_pc, op_taken, op_target} !== 65'b0) begin failures++; $display("FAIL rst_operands got %h want 0", {op_pc, op_taken, op_target}); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_pred();
        pred_valid = 1'b1; pred_pc = 32'h1000;
        checks++; if (pred_ready !== 1'b1) begin failures++; $display("FAIL t1_ready_n got %b want 1", pred_ready); end
        tick(); pred_valid = 1'b0;                                   // N+1 ISSUE
        checks++; if ({start_pred, start_resolve} !== 2'b10) begin failures++; $display("FAIL t1_issue_starts got %b want 10", {start_pred, start_resolve}); end
        checks++; if (op_pc !== 32'h1000) begin failures++; $display("FAIL t1_op_pc got %h want 00001000", op_pc); end
        checks++; if (op_taken !== 1'b0) begin failures++; $display("FAIL t1_op_taken got %b want 0", op_taken); end
        checks++; if ({busy, pred_ready} !== 2'b10) begin failures++; $display("FAIL t1_busy_ready got %b want 10", {busy, pred_ready}); end
        tick();                                                      // N+2 HOLD
        checks++; if ({start_pred, start_resolve} !== 2'b00) begin failures++; $display("FAIL t1_hold_starts got %b want 00", {start_pred, start_resolve}); end
        tick(); done = 1'b1;                                         // N+3 WAIT
        checks++; if ({start_pred, pred_done, op_pc == 32'h1000} !== 3'b001) begin failures++; $display("FAIL t1_wait got %b want 001", {start_pred, pred_done, op_pc == 32'h1000}); end
        tick(); done = 1'b0;                                         // N+4
        checks++; if (pred_done !== 1'b1) begin failures++; $display("FAIL t1_pred_done got %b want 1", pred_done); end
        checks++; if ({pred_ready, busy, res_done} !== 3'b100) begin failures++; $display("FAIL t1_after got %b want 100", {pred_ready, busy, res_done}); end
        tick();
        checks++; if (pred_done !== 1'b0) begin failures++; $display("FAIL t1_pulse_width got %b want 0", pred_done); end
    endtask

    task automatic test_single_resolve();
        int pulses;
        res_valid = 1'b1; res_pc = 32'h2000; res_taken = 1'b1; res_target = 32'h2400;
        checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL t2_ready got %b want 1", res_ready); end
        tick(); res_valid = 1'b0;                                    // N+1 still IDLE
        checks++; if ({busy, start_resolve} !== 2'b00) begin failures++; $display("FAIL t2_eligible_next got %b want 00", {busy, start_resolve}); end
        tick();                                                      // N+2 ISSUE
        checks++; if ({start_pred, start_resolve} !== 2'b01) begin failures++; $display("FAIL t2_issue_starts got %b want 01", {start_pred, start_resolve}); end
        checks++; if ({op_pc, op_taken, op_target} !== {32'h2000, 1'b1, 32'h2400}) begin failures++; $display("FAIL t2_operands got %h want %h", {op_pc, op_taken, op_target}, {32'h2000, 1'b1, 32'h2400}); end
        tick();                                                      // N+3 HOLD
        checks++; if ({start_pred, start_resolve} !== 2'b01) begin failures++; $display("FAIL t2_hold_starts got %b want 01", {start_pred, start_resolve}); end
        tick(); done = 1'b1;                                         // N+4 WAIT
        checks++; if ({start_resolve, op_taken} !== 2'b01) begin failures++; $display("FAIL t2_wait got %b want 01", {start_resolve, op_taken}); end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); done = 1'b0;
            pulses += int'(res_done);
        end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL t2_res_done_count got %0d want 1", pulses); end
    endtask

    task automatic test_priority();
        pred_valid = 1'b1; pred_pc = 32'h3000;
        res_valid  = 1'b1; res_pc  = 32'h3100; res_taken = 1'b0; res_target = 32'h3200;
        tick(); pred_valid = 1'b0; res_valid = 1'b0;                 // N+1
        checks++; if ({busy, pred_ready} !== 2'b00) begin failures++; $display("FAIL t3_slot got %b want 00", {busy, pred_ready}); end
        tick();                                                      // N+2 resolve ISSUE
        checks++; if ({start_pred, start_resolve, op_pc} !== {2'b01, 32'h3100}) begin failures++; $display("FAIL t3_res_first got %h want %h", {start_pred, start_resolve, op_pc}, {2'b01, 32'h3100}); end
        tick(); tick(); done = 1'b1;                                 // N+4 WAIT
        tick(); done = 1'b0;                                         // N+5 pred ISSUE
        checks++; if (res_done !== 1'b1) begin failures++; $display("FAIL t3_res_done got %b want 1", res_done); end
        checks++; if ({start_pred, start_resolve, op_taken, op_pc} !== {3'b100, 32'h3000}) begin failures++; $display("FAIL t3_pred_next got %h want %h", {start_pred, start_resolve, op_taken, op_pc}, {3'b100, 32'h3000}); end
        tick(); tick(); done = 1'b1;                                 // N+7 WAIT
        tick(); done = 1'b0;                                         // N+8
        checks++; if ({pred_done, pred_ready, busy} !== 3'b110) begin failures++; $display("FAIL t3_pred_done got %b want 110", {pred_done, pred_ready, busy}); end
    endtask

    task automatic test_queue_full();
        logic [31:0] exp_pc  [5];
        logic [31:0] exp_tgt [5];
        logic        exp_tk  [5];
        for (int i = 0; i < 5; i++) begin
            exp_pc[i]  = 32'h5000 + 32'(i * 16);
            exp_tgt[i] = 32'h6000 + 32'(i * 16);
            exp_tk[i]  = (i % 2) == 1;
        end
        pred_valid = 1'b1; pred_pc = 32'h4000;                       // M
        tick(); pred_valid = 1'b0;                                   // M+1 pred ISSUE
        for (int i = 0; i < 4; i++) begin                            // pushes at M+1..M+4
            res_valid = 1'b1; res_pc = exp_pc[i]; res_taken = exp_tk[i]; res_target = exp_tgt[i];
            checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL t4_ready_%0d got %b want 1", i, res_ready); end
            tick();
        end
        res_pc = exp_pc[4]; res_taken = exp_tk[4]; res_target = exp_tgt[4];   // M+5
        checks++; if (res_ready !== 1'b0) begin failures++; $display("FAIL t4_full got %b want 0", res_ready); end
        tick(); done = 1'b1;                                         // M+6 still WAIT
        checks++; if ({res_ready, busy} !== 2'b01) begin failures++; $display("FAIL t4_full_hold got %b want 01", {res_ready, busy}); end
        tick(); done = 1'b0;                                         // M+7 ISSUE entry0
        checks++; if ({pred_done, start_resolve, res_ready} !== 3'b110) begin failures++; $display("FAIL t4_first_pop got %b want 110", {pred_done, start_resolve, res_ready}); end
        checks++; if ({op_pc, op_taken, op_target} !== {exp_pc[0], exp_tk[0], exp_tgt[0]}) begin failures++; $display("FAIL t4_entry0 got %h want %h", {op_pc, op_taken, op_target}, {exp_pc[0], exp_tk[0], exp_tgt[0]}); end
        tick();                                                      // M+8 HOLD, room again
        checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL t4_fifth_accept got %b want 1", res_ready); end
        tick(); res_valid = 1'b0; done = 1'b1;                       // M+9 WAIT
        checks++; if (res_ready !== 1'b0) begin failures++; $display("FAIL t4_full_again got %b want 0", res_ready); end
        for (int k = 1; k < 5; k++) begin
            tick(); done = 1'b0;                                     // ISSUE entry k
            checks++; if ({res_done, start_resolve} !== 2'b11) begin failures++; $display("FAIL t4_b2b_%0d got %b want 11", k, {res_done, start_resolve}); end
            checks++; if ({op_pc, op_taken, op_target} !== {exp_pc[k], exp_tk[k], exp_tgt[k]}) begin failures++; $display("FAIL t4_entry%0d got %h want %h", k, {op_pc, op_taken, op_target}, {exp_pc[k], exp_tk[k], exp_tgt[k]}); end
            tick(); tick(); done = 1'b1;
        end
        tick(); done = 1'b0;
        checks++; if ({res_done, busy, res_ready} !== 3'b101) begin failures++; $display("FAIL t4_drain got %b want 101", {res_done, busy, res_ready}); end
`ifdef BP_SEQ_STATS_EN
        checks++; if ({stat_pred, stat_res, stat_stall} !== {16'd3, 16'd7, 16'd3}) begin failures++; $display("FAIL t4_stats got %h want %h", {stat_pred, stat_res, stat_stall}, {16'd3, 16'd7, 16'd3}); end
`endif
    endtask

    task automatic test_timeout();
        int pulses;
        pred_valid = 1'b1; pred_pc = 32'h7000;                       // T
        tick(); pred_valid = 1'b0;                                   // T+1 ISSUE
        tick(); tick();                                              // T+3 WAIT #1
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            pulses += int'(pred_done) + int'(res_done);
            tick();
        end                                                          // T+17 WAIT #15
        checks++; if ({busy, timeout_err} !== 2'b10) begin failures++; $display("FAIL t5_last_wait got %b want 10", {busy, timeout_err}); end
        tick();                                                      // T+18
        pulses += int'(pred_done) + int'(res_done);
        checks++; if ({busy, timeout_err, pred_ready} !== 3'b011) begin failures++; $display("FAIL t5_abort got %b want 011", {busy, timeout_err, pred_ready}); end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL t5_no_done got %0d want 0", pulses); end
        done = 1'b1;                                                 // stray done while idle
        tick(); done = 1'b0;
        checks++; if ({pred_done, res_done, busy, timeout_err} !== 4'b0001) begin failures++; $display("FAIL t5_stray_done got %b want 0001", {pred_done, res_done, busy, timeout_err}); end
    endtask

    task automatic test_reset_mid_op();
        int busy_seen;
        pred_valid = 1'b1; pred_pc = 32'h8000;
        res_valid  = 1'b1; res_pc  = 32'h9000; res_taken = 1'b1; res_target = 32'h9400;
        tick(); pred_valid = 1'b0; res_pc = 32'h9100;                // R+1 second push
        tick(); res_valid = 1'b0;                                    // R+2 ISSUE
        tick();                                                      // R+3 HOLD
        checks++; if ({start_resolve, pred_ready, res_ready} !== 3'b101) begin failures++; $display("FAIL t6_pre got %b want 101", {start_resolve, pred_ready, res_ready}); end
        rst = 1'b0;
        #1;
        checks++; if ({start_pred, start_resolve, busy} !== 3'b000) begin failures++; $display("FAIL t6_starts got %b want 000", {start_pred, start_resolve, busy}); end
        checks++; if ({pred_ready, res_ready, timeout_err} !== 3'b110) begin failures++; $display("FAIL t6_flush got %b want 110", {pred_ready, res_ready, timeout_err}); end
`ifdef BP_SEQ_STATS_EN
        checks++; if ({stat_pred, stat_res, stat_stall} !== 48'd0) begin failures++; $display("FAIL t6_stats got %h want 0", {stat_pred, stat_res, stat_stall}); end
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            busy_seen += int'(busy) + int'(start_resolve) + int'(start_pred);
        end
        checks++; if (busy_seen !== 0) begin failures++; $display("FAIL t6_queue_empty got %0d want 0", busy_seen); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_pred();
        tick();
        test_single_resolve();
        tick();
        test_priority();
        tick();
        test_queue_full();
        tick();
        test_timeout();
        tick();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
